bcd_to_binary_seq: RTL and testbench
====================================

// Module: bcd_to_binary_seq
// PURPOSE
//   Sequential 7-digit BCD to binary converter using reverse double dabble:
//   shift right, then subtract 3 from every digit that is >=8, one bit per clock.
//   Inverse of the combinational binary-to-BCD path: it takes digits entered by
//   keypad or switches and returns an 18-bit binary value to the datapath.
//   Uses a start/busy/done handshake.
//   Flags a digit above 9 and a result too large for the output width.
// PARAMETERS
//   OUT_W  18  binary output width; results above 2^OUT_W-1 saturate and set overflow
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      1-cycle request; sampled only in IDLE
//   bcd6      in   4      most significant BCD digit
//   bcd5..bcd1 in  4 each intermediate BCD digits
//   bcd0      in   4      least significant BCD digit
//   binary    out  OUT_W  converted value; held until next completion
//   busy      out  1      conversion in progress
//   done      out  1      1-cycle pulse; binary/overflow/err_digit valid
//   overflow  out  1      value > 2^OUT_W-1; binary = all ones
//   err_digit out  1      some input digit > 9; binary = 0
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; binary=0, busy=0, done=0, overflow=0, err_digit=0.
//   Clears all internal regs. Reset mid-conversion aborts with no done pulse.
// - Internal register: 28-bit BCD field {d6..d0} over a 24-bit binary field.
//   52 bits in total. 24 iterations because 2^24 > 9_999_999.
// - States:
//   IDLE:
//     - On an edge with start=1, latch bcd6..bcd0 into the BCD field and clear the binary field.
//     - If any digit >9, go to FIN with err.
//     - Otherwise go to SHIFT with iteration count cnt=0, and busy=1 after that edge.
//   SHIFT:
//     - Each edge: shift the whole 52-bit reg right by 1.
//     - Then, for each 4-bit digit of the shifted BCD field: if digit >=8, subtract 3.
//       All digits are corrected in the same cycle.
//     - cnt increments. After the 24th shift, go to FIN.
//   FIN (one cycle, combinational decision, registered outputs):
//     - busy=0, done=1 for exactly one cycle. Then IDLE.
//     - err: binary=0, err_digit=1, overflow=0.
//     - else if binary field >= 2^OUT_W: binary={OUT_W{1}}, overflow=1, err_digit=0.
//     - else: binary=field[OUT_W-1:0], overflow=0, err_digit=0.
// - Latency, with start sampled at edge k:
//   - Valid input: 24 shifts at edges k+1..k+24; outputs update and done=1 after edge k+25.
//   - Invalid digit: done after edge k+1.
// - done may coincide with IDLE on the next edge. A start on the edge after done is
//   accepted, giving back-to-back conversions 26 cycles apart.
// - Start while busy or in FIN is ignored, not queued. Input digits are not sampled after load.
// - binary, overflow and err_digit change only at completion; they hold between conversions.
// - OUT_W >= 24: overflow is never set and binary is zero-extended.
// TESTING
// 1. Digits 0,2,6,2,1,4,3 (262143), start -> done 25 cycles later, binary=18'h3FFFF,
//    overflow=0, err_digit=0.
// 2. All digits 0 -> binary=0; then 0000001 -> binary=1. Second start issued on the
//    cycle after done is accepted.
// 3. Digits 0262144 -> overflow=1, binary=18'h3FFFF. Digits 9999999 -> overflow=1.
//    Repeat with OUT_W=24: binary=24'h98967F.
// 4. bcd3=4'hA -> done 1 cycle after start, err_digit=1, binary=0.
//    Next valid conversion clears err_digit.
// 5. Start again at cycle 10 of a conversion of 0123456 -> ignored, no extra done,
//    binary=123456. Input digits changed mid-conversion do not affect the result.
// 6. rst_n low at cycle 12 of a conversion -> all outputs 0 at once, no done.
//    After release, a new start of 0000042 -> binary=42.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: 7-digit BCD to binary converter, reverse double dabble, one bit per clock
module bcd_to_binary_seq #(
  parameter int OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       bcd6,
  input  logic [3:0]       bcd5,
  input  logic [3:0]       bcd4,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  output logic [OUT_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             err_digit
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t             r_state, w_next;
  logic [51:0]        r_sr, w_shift, w_corr;
  logic [4:0]         r_cnt;
  logic               r_err, r_done, r_ovf, r_errd;
  logic [OUT_W-1:0]   r_binary;
  logic               w_bad, w_ovf;
  logic [23:0]        w_field;
  logic [OUT_W+23:0]  w_ext;
  assign w_bad = (bcd6 > 4'd9) | (bcd5 > 4'd9) | (bcd4 > 4'd9) | (bcd3 > 4'd9) |
                 (bcd2 > 4'd9) | (bcd1 > 4'd9) | (bcd0 > 4'd9);
  assign w_field = r_sr[23:0];
  assign w_ext   = {{OUT_W{1'b0}}, w_field};
  assign w_ovf   = |(w_field >> OUT_W);
  assign w_shift = r_sr >> 1;
  // after the shift, any digit that reached 8 or more borrowed a half-weight bit: take 3 back
  always_comb begin
    w_corr = w_shift;
    for (int i = 0; i < 7; i++)
      w_corr[24+4*i +: 4] = (w_shift[24+4*i +: 4] >= 4'd8) ? w_shift[24+4*i +: 4] - 4'd3
                                                           : w_shift[24+4*i +: 4];
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (w_bad ? FIN : SHIFT) : IDLE;
      SHIFT:   w_next = (r_cnt == 5'd23) ? FIN : SHIFT;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // conversion datapath and registered results, which only move when a conversion finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_errd   <= 1'b0;
      r_binary <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_sr  <= {bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0, 24'd0};
          r_cnt <= '0;
          r_err <= w_bad;
        end
        SHIFT: begin
          r_sr  <= w_corr;
          r_cnt <= r_cnt + 5'd1;
        end
        FIN: begin
          r_done   <= 1'b1;
          r_errd   <= r_err;
          r_ovf    <= !r_err && w_ovf;
          r_binary <= r_err ? '0 : (w_ovf ? '1 : w_ext[OUT_W-1:0]);
        end
        default: ;
      endcase
    end
  end
  // outputs
  always_comb begin
    busy      = (r_state == SHIFT);
    done      = r_done;
    overflow  = r_ovf;
    err_digit = r_errd;
    binary    = r_binary;
  end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed and random checks of the BCD converter at OUT_W=18 and OUT_W=24
module tb_bcd_to_binary_seq;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [27:0] dig = '0;
  logic [17:0] bin_a;
  logic [23:0] bin_b;
  logic        busy_a, done_a, ovf_a, err_a;
  logic        busy_b, done_b, ovf_b, err_b;
  int          total = 0, bad = 0;

  bcd_to_binary_seq #(.OUT_W(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bcd6(dig[27:24]), .bcd5(dig[23:20]), .bcd4(dig[19:16]), .bcd3(dig[15:12]),
    .bcd2(dig[11:8]), .bcd1(dig[7:4]), .bcd0(dig[3:0]),
    .binary(bin_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .err_digit(err_a));

  bcd_to_binary_seq #(.OUT_W(24)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bcd6(dig[27:24]), .bcd5(dig[23:20]), .bcd4(dig[19:16]), .bcd3(dig[15:12]),
    .bcd2(dig[11:8]), .bcd1(dig[7:4]), .bcd0(dig[3:0]),
    .binary(bin_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .err_digit(err_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " bin_a"}, 64'(bin_a), 0);
    chk({tag, " bin_b"}, 64'(bin_b), 0);
    chk({tag, " busy"},  64'({busy_a, busy_b}), 0);
    chk({tag, " done"},  64'({done_a, done_b}), 0);
    chk({tag, " ovf"},   64'({ovf_a, ovf_b}), 0);
    chk({tag, " err"},   64'({err_a, err_b}), 0);
  endtask

  // Called at a negedge; returns at the negedge where done is visible, so a
  // follow-up call issues a back-to-back start.
  task automatic conv(input logic [27:0] d, input string tag);
    bit     e = 0;
    longint v = 0;
    int     n = 0;
    for (int i = 6; i >= 0; i--) begin
      if (d[4*i +: 4] > 4'd9) e = 1;
      v = v * 10 + longint'(d[4*i +: 4]);
    end
    dig = d;
    start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, " busy"}, 64'({busy_a, busy_b}), e ? 0 : 3);
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), e ? 1 : 25);
    chk({tag, " done_b"}, 64'(done_b), 1);
    chk({tag, " bin_a"}, 64'(bin_a), e ? 0 : (v > 262143 ? 64'h3FFFF : 64'(v)));
    chk({tag, " ovf_a"}, 64'(ovf_a), (!e && v > 262143) ? 1 : 0);
    chk({tag, " err_a"}, 64'(err_a), 64'(e));
    chk({tag, " bin_b"}, 64'(bin_b), e ? 0 : 64'(v));
    chk({tag, " ovf_b"}, 64'(ovf_b), 0);
    chk({tag, " err_b"}, 64'(err_b), 64'(e));
  endtask

  initial begin
    int n, extra;
    logic [27:0] r;
    #23;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    conv(28'h0262143, "max18");
    @(negedge clk);
    chk("done one cycle", 64'({done_a, done_b}), 0);
    conv(28'h0000000, "zero");
    conv(28'h0000001, "b2b one");
    @(negedge clk);
    conv(28'h0262144, "ovf18");
    @(negedge clk);
    conv(28'h9999999, "max bcd");
    @(negedge clk);
    conv(28'h000A000, "bad digit");
    @(negedge clk);
    conv(28'h0000007, "clear err");
    @(negedge clk);
    // start and digit changes during a conversion are ignored
    dig = 28'h0123456;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 10) begin start = 1; dig = 28'h9876543; end
      if (n == 11) start = 0;
    end
    chk("ignored start latency", 64'(n), 25);
    chk("ignored start bin_a", 64'(bin_a), 123456);
    chk("ignored start bin_b", 64'(bin_b), 123456);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_a || done_b) extra++;
    end
    chk("no extra done", 64'(extra), 0);
    // reset mid-conversion aborts silently
    dig = 28'h0123456;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("mid reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_a || done_b) extra++;
    end
    chk("no done after abort", 64'(extra), 0);
    conv(28'h0000042, "after reset");
    @(negedge clk);
    // random digits, occasionally out of range
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 7; i++)
        r[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      conv(r, $sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
